an_encoder_seq: RTL and testbench

//  Sequential AN-code encoder: computes AN = A*N by shift-and-add, one multiplier bit per cycle.

---
 rtl/an_pkg.sv | 17 +
 rtl/an_encoder_seq.sv | 131 +++++++++++++
 tb/tb_an_encoder_seq.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/an_pkg.sv
// Shared AN-code constants and encoder FSM state encoding.
// The combinational AN decoder imports the same constants.
package an_pkg;

    localparam int AN_A     = 61;
    localparam int AN_A_W   = 6;
    localparam int AN_N_W   = 24;
    localparam int AN_W     = 30;
    localparam int AN_POS_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } an_state_t;

endpackage

// File: rtl/an_encoder_seq.sv
// Sequential AN-code encoder: out_ref = A*N computed by shift-and-add,
// one multiplier bit per cycle. out_an is the same codeword, optionally
// with a single bit flipped for error-injection runs.
module an_encoder_seq
    import an_pkg::*;
#(
    parameter int N_W   = AN_N_W,
    parameter int A     = AN_A,
    parameter int A_W   = AN_A_W,
    parameter int AN_W  = an_pkg::AN_W,
    parameter int POS_W = AN_POS_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_W-1:0]   in_n,
    input  logic             inj_en,
    input  logic [POS_W-1:0] inj_pos,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [AN_W-1:0]  out_an,
    output logic [AN_W-1:0]  out_ref
);

    localparam int                 CNT_W    = $clog2(A_W + 1);
    localparam logic [A_W-1:0]     A_BITS   = A_W'(A);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(A_W - 1);

    // Parameter legality is enforced at elaboration.
    if (A % 2 == 0) begin : g_chk_a_odd
        $error("an_encoder_seq: A must be odd");
    end
    if (A >= (1 << A_W)) begin : g_chk_a_range
        $error("an_encoder_seq: A must be below 2**A_W");
    end
    if (AN_W != N_W + A_W) begin : g_chk_an_w
        $error("an_encoder_seq: AN_W must equal N_W + A_W");
    end
    if ((1 << POS_W) < AN_W) begin : g_chk_pos_w
        $error("an_encoder_seq: 2**POS_W must cover AN_W");
    end
    if (64'(A) * ((64'd1 << N_W) - 64'd1) >= (64'd1 << AN_W)) begin : g_chk_ovf
        $error("an_encoder_seq: A*(2**N_W-1) must fit in AN_W bits");
    end

    an_state_t        state;
    an_state_t        state_next;
    logic [N_W-1:0]   n_q;
    logic             inj_en_q;
    logic [POS_W-1:0] inj_pos_q;
    logic [AN_W-1:0]  acc;
    logic [AN_W-1:0]  acc_next;
    logic [AN_W-1:0]  flip_mask;
    logic [CNT_W-1:0] cnt;
    logic             mul_last;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = MUL;
            end
            MUL: begin
                if (mul_last) state_next = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Partial-product add for the current multiplier bit and the injection mask.
    always_comb begin
        mul_last  = (state == MUL) && (cnt == CNT_LAST);
        acc_next  = acc;
        if (A_BITS[cnt]) acc_next = acc + (AN_W'(n_q) << cnt);
        flip_mask = '0;
        if (inj_en_q && (32'(inj_pos_q) < AN_W)) flip_mask = AN_W'(1) << inj_pos_q;
    end

    // Input capture, shift-add accumulator and output codeword registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q       <= '0;
            inj_en_q  <= 1'b0;
            inj_pos_q <= '0;
            acc       <= '0;
            cnt       <= '0;
            out_an    <= '0;
            out_ref   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        n_q       <= in_n;
                        inj_en_q  <= inj_en;
                        inj_pos_q <= inj_pos;
                        acc       <= '0;
                        cnt       <= '0;
                    end
                end
                MUL: begin
                    acc <= acc_next;
                    cnt <= cnt + CNT_W'(1);
                    if (mul_last) begin
                        out_ref <= acc_next;
                        out_an  <= acc_next ^ flip_mask;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_an_encoder_seq.sv
// Self-checking bench for an_encoder_seq: directed corner cases plus a
// random loopback through a behavioural single-error-correcting AN decoder.
module tb_an_encoder_seq;
    import an_pkg::*;

    localparam int N_W   = 24;
    localparam int A_W   = 6;
    localparam int CW    = 30;
    localparam int POS_W = 5;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [N_W-1:0]   in_n;
    logic             inj_en;
    logic [POS_W-1:0] inj_pos;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    out_an;
    logic [CW-1:0]    out_ref;

    int checks = 0;
    int errors = 0;

    an_encoder_seq #(
        .N_W  (N_W),
        .A    (61),
        .A_W  (A_W),
        .AN_W (CW),
        .POS_W(POS_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_n     (in_n),
        .inj_en   (inj_en),
        .inj_pos  (inj_pos),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_an   (out_an),
        .out_ref  (out_ref)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural AN decoder: exact multiple of 61, else try every single-bit flip.
    function automatic longint an_decode(input longint v);
        longint c;
        if (v % 61 == 0) return v / 61;
        for (int i = 0; i < CW; i++) begin
            c = v ^ (longint'(1) << i);
            if (c % 61 == 0 && c / 61 < (longint'(1) << N_W)) return c / 61;
        end
        return -1;
    endfunction

    // One full transaction starting at a negedge; checks latency, stability and handshakes.
    task automatic do_word(input logic [N_W-1:0] n, input logic en, input logic [POS_W-1:0] pos,
                           input int hold, output logic [CW-1:0] got_an);
        longint exp_ref;
        longint exp_an;
        bit     seen;
        exp_ref = 61 * longint'(n);
        exp_an  = exp_ref;
        if (en && pos < CW) exp_an = exp_an ^ (longint'(1) << pos);
        got_an = '0;

        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready === 1'b1) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL in_ready_wait got %b expected 1 within 20 cycles", in_ready);
            return;
        end

        in_valid = 1'b1;
        in_n     = n;
        inj_en   = en;
        inj_pos  = pos;
        @(posedge clk);
        #1;
        // Scramble inputs after acceptance; in_valid stays high and must be ignored.
        in_n    = N_W'($urandom);
        inj_en  = 1'($urandom);
        inj_pos = POS_W'($urandom);

        for (int k = 1; k <= A_W; k++) begin
            if (k == A_W) in_valid = 1'b0;
            out_ready = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (out_valid !== (k == A_W)) begin
                errors++;
                $display("FAIL latency edge %0d out_valid got %b expected %b", k, out_valid, (k == A_W));
            end
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL busy_in_ready edge %0d got %b expected 0", k, in_ready);
            end
        end

        for (int h = 0; h <= hold; h++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_flags n=%0d cycle %0d out_valid=%b in_ready=%b expected 1/0",
                         n, h, out_valid, in_ready);
            end
            checks++;
            if (out_ref !== exp_ref[CW-1:0]) begin
                errors++;
                $display("FAIL out_ref n=%0d got %0d expected %0d", n, out_ref, exp_ref);
            end
            checks++;
            if (out_an !== exp_an[CW-1:0]) begin
                errors++;
                $display("FAIL out_an n=%0d en=%b pos=%0d got %0d expected %0d", n, en, pos, out_an, exp_an);
            end
            out_ready = (h == hold);
            if (h < hold) @(negedge clk);
        end
        got_an = out_an;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_handshake out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_an !== '0 || out_ref !== '0) begin
            errors++;
            $display("FAIL reset_state in_ready=%b out_valid=%b out_an=%0d out_ref=%0d expected 1/0/0/0",
                     in_ready, out_valid, out_an, out_ref);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_basic;
        logic [CW-1:0] g;
        do_word(24'd0, 1'b0, 5'd0, 0, g);
        do_word(24'd1, 1'b0, 5'd0, 0, g);
        do_word(24'd2, 1'b0, 5'd0, 0, g);
        do_word(24'hFFFFFF, 1'b0, 5'd0, 0, g);
        checks++;
        if (g !== 30'd1023410115) begin
            errors++;
            $display("FAIL max_word got %0d expected 1023410115", g);
        end
    endtask

    task automatic test_injection;
        logic [CW-1:0] g;
        do_word(24'd5, 1'b1, 5'd0, 0, g);
        checks++;
        if (g !== 30'd304) begin
            errors++;
            $display("FAIL inj_pos0 got %0d expected 304", g);
        end
        do_word(24'd5, 1'b1, 5'd29, 0, g);
        do_word(24'd5, 1'b1, 5'd31, 0, g);
        checks++;
        if (g !== 30'd305) begin
            errors++;
            $display("FAIL inj_pos31 got %0d expected 305", g);
        end
        do_word(24'd5, 1'b0, 5'd3, 0, g);
    endtask

    task automatic test_backpressure;
        logic [CW-1:0] g;
        do_word(N_W'($urandom), 1'b1, 5'($urandom_range(0, 29)), 10, g);
        do_word(N_W'($urandom), 1'b0, 5'd0, 3, g);
    endtask

    task automatic test_reset_mid_mul;
        logic [CW-1:0] g;
        in_valid = 1'b1;
        in_n     = N_W'($urandom);
        inj_en   = 1'b1;
        inj_pos  = 5'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_an !== '0 || out_ref !== '0) begin
            errors++;
            $display("FAIL reset_mid_mul out_valid=%b in_ready=%b out_an=%0d out_ref=%0d expected 0/1/0/0",
                     out_valid, in_ready, out_an, out_ref);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_word(24'd3, 1'b0, 5'd0, 0, g);
        checks++;
        if (g !== 30'd183) begin
            errors++;
            $display("FAIL after_reset_word got %0d expected 183", g);
        end
    endtask

    task automatic test_back_to_back_loopback;
        logic [CW-1:0]  g;
        logic [N_W-1:0] n;
        longint         d;
        for (int i = 0; i < 1000; i++) begin
            n = N_W'($urandom);
            do_word(n, 1'b1, 5'($urandom_range(0, 29)), int'($urandom_range(0, 2)), g);
            d = an_decode(longint'(g));
            checks++;
            if (d != longint'(n)) begin
                errors++;
                $display("FAIL loopback iter %0d decoded %0d expected %0d", i, d, n);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_n      = '0;
        inj_en    = 1'b0;
        inj_pos   = '0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_injection();
        test_backpressure();
        test_reset_mid_mul();
        test_back_to_back_loopback();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
